// File: rtl/fdc_pkg.sv
// fdc_pkg: shared state encodings, status bit positions and defaults for the fdc1772 sector path.
package fdc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_WAIT_DATA, S_XFER, S_FINISH} state_t;
  localparam int RNF = 0;
  localparam int LOST = 1;
  localparam int NRDY = 2;
  localparam int INDEX_TIMEOUT_DEF = 5;
endpackage

// File: rtl/fdc_edge_det.sv
// fdc_edge_det: registered rise/fall detector; pulses appear one cycle after the input edge.
module fdc_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      prev <= d;
      rise <= d & ~prev;
      fall <= ~d & prev;
    end
endmodule

// File: rtl/fdc_sector_seq.sv
// fdc_sector_seq: locates a requested sector on the virtual drive and paces its bytes as DRQ requests.
module fdc_sector_seq
  import fdc_pkg::*;
#(
  parameter int INDEX_TIMEOUT = INDEX_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_write,
  input  logic        cmd_multi,
  input  logic [6:0]  cmd_track,
  input  logic [4:0]  cmd_sector,
  input  logic [10:0] sector_len,
  input  logic        sector_base,
  input  logic [4:0]  spt,
  input  logic        abort,
  input  logic        dclk_en,
  input  logic        ready,
  input  logic        index,
  input  logic [6:0]  track,
  input  logic [4:0]  sector,
  input  logic        sector_hdr,
  input  logic        sector_data,
  output logic        drq,
  input  logic        drq_ack,
  output logic [10:0] byte_idx,
  output logic [4:0]  cur_sector,
  output logic        busy,
  output logic        done,
  output logic        rnf,
  output logic        lost_data,
  output logic        not_ready
);
  state_t state;
  logic wr, multi, first;
  logic [6:0] trk;
  logic [2:0] idx_cnt, stat;
  logic idx_rise, idx_fall, hdr_rise, hdr_fall, data_rise, data_fall;
  logic strobe, unused_edges;
  logic [10:0] nidx;
  logic [5:0] nsec, last_sec;
  fdc_edge_det u_idx (.clk(clk), .reset(reset), .d(index), .rise(idx_rise), .fall(idx_fall));
  fdc_edge_det u_hdr (.clk(clk), .reset(reset), .d(sector_hdr), .rise(hdr_rise), .fall(hdr_fall));
  fdc_edge_det u_dat (.clk(clk), .reset(reset), .d(sector_data), .rise(data_rise), .fall(data_fall));
  assign unused_edges = idx_rise ^ hdr_fall;
  assign strobe = (state == S_XFER) && dclk_en && sector_data;
  assign nidx = first ? 11'd0 : byte_idx + 11'd1;
  assign nsec = 6'(cur_sector) + 6'd1;
  assign last_sec = 6'(sector_base) + 6'(spt) - 6'd1;
  assign rnf = stat[RNF];
  assign lost_data = stat[LOST];
  assign not_ready = stat[NRDY];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      {drq, busy, done, wr, multi, first} <= '0;
      {trk, idx_cnt, stat, byte_idx, cur_sector} <= '0;
    end else begin
      done <= 1'b0;
      // A strobe re-arms drq even if the CPU acks in the same cycle; only an unacked drq loses data.
      if (strobe) begin
        drq <= 1'b1;
        if (drq && !drq_ack) stat[LOST] <= 1'b1;
      end else if (drq_ack) drq <= 1'b0;
      if (abort && state != S_IDLE && state != S_FINISH) begin
        state <= S_FINISH;
        drq <= 1'b0;
      end else case (state)
        S_IDLE: begin
          busy <= start && !busy;
          if (start && !busy) begin
            {wr, multi, trk, cur_sector} <= {cmd_write, cmd_multi, cmd_track, cmd_sector};
            idx_cnt <= '0;
            stat <= {!ready, 2'b00};
            state <= ready ? S_SEARCH : S_FINISH;
          end
        end
        S_SEARCH:
          if (idx_fall) begin
            idx_cnt <= (idx_cnt == 3'd7) ? idx_cnt : idx_cnt + 3'd1;
            if (idx_cnt == 3'(INDEX_TIMEOUT - 1)) begin
              stat[RNF] <= 1'b1;
              state <= S_FINISH;
            end
          end else if (hdr_rise && sector == cur_sector && track == trk) begin
            state <= S_WAIT_DATA;
            if (wr) drq <= 1'b1;
          end
        S_WAIT_DATA:
          if (data_rise) begin
            if (wr && drq) begin
              stat[LOST] <= 1'b1;
              drq <= 1'b0;
              state <= S_FINISH;
            end else begin
              byte_idx <= '0;
              first <= 1'b1;
              state <= S_XFER;
            end
          end
        S_XFER:
          if (strobe) begin
            byte_idx <= nidx;
            first <= 1'b0;
            if (nidx == sector_len - 11'd1) begin
              if (multi) begin
                cur_sector <= nsec[4:0];
                idx_cnt <= '0;
                stat[RNF] <= nsec > last_sec;
                state <= (nsec > last_sec) ? S_FINISH : S_SEARCH;
              end else state <= S_FINISH;
            end
          end else if (data_fall) begin
            stat[LOST] <= 1'b1;
            state <= S_FINISH;
          end
        S_FINISH: begin
          done <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_fdc_sector_seq.sv
// tb_fdc_sector_seq: directed bench driving a scripted drive model against fdc_sector_seq.
module tb_fdc_sector_seq;
  logic clk = 1'b0;
  logic reset, start, cmd_write, cmd_multi, abort, dclk_en, ready, index;
  logic sector_hdr, sector_data, drq_ack, sector_base;
  logic [6:0] cmd_track, track;
  logic [4:0] cmd_sector, spt, sector;
  logic [10:0] sector_len;
  logic drq, busy, done, rnf, lost_data, not_ready;
  logic [10:0] byte_idx;
  logic [4:0] cur_sector;
  int checks = 0, errors = 0;
  int drq_rises = 0, done_cnt = 0, idx_bad = 0, d0, r0;
  logic drq_q = 1'b0, lost0, lost1;

  fdc_sector_seq dut (
    .clk(clk), .reset(reset), .start(start), .cmd_write(cmd_write), .cmd_multi(cmd_multi),
    .cmd_track(cmd_track), .cmd_sector(cmd_sector), .sector_len(sector_len),
    .sector_base(sector_base), .spt(spt), .abort(abort), .dclk_en(dclk_en), .ready(ready),
    .index(index), .track(track), .sector(sector), .sector_hdr(sector_hdr),
    .sector_data(sector_data), .drq(drq), .drq_ack(drq_ack), .byte_idx(byte_idx),
    .cur_sector(cur_sector), .busy(busy), .done(done), .rnf(rnf), .lost_data(lost_data),
    .not_ready(not_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (drq && !drq_q) drq_rises++;
    drq_q = drq;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic w, input logic m, input logic [6:0] t, input logic [4:0] s);
    {cmd_write, cmd_multi, cmd_track, cmd_sector} = {w, m, t, s};
    d0 = done_cnt;
    r0 = drq_rises;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic hdr(input logic [6:0] t, input logic [4:0] s);
    track = t;
    sector = s;
    sector_hdr = 1'b1;
    tick; tick; tick;
    sector_hdr = 1'b0;
    tick;
  endtask

  task automatic index_pulse;
    index = 1'b0;
    tick; tick;
    index = 1'b1;
    tick; tick;
  endtask

  task automatic wait_idle(input int max);
    int k = 0;
    while (busy && k < max) begin
      tick;
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic data_phase(input int n, input bit ack, input int abort_at, input int rst_at);
    int bad = 0;
    sector_data = 1'b1;
    tick; tick; tick;
    for (int i = 0; i < n; i++) begin
      dclk_en = 1'b1;
      tick;
      dclk_en = 1'b0;
      if (byte_idx != 11'(i)) bad++;
      if (i == 0) lost0 = lost_data;
      if (i == 1) lost1 = lost_data;
      if (i == abort_at) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_drq", drq, 0);
        tick;
        check("abort_done", done, 1);
        tick;
        check("abort_busy", busy, 0);
        check("abort_idx", byte_idx, 100);
        check("abort_status", {rnf, lost_data, not_ready}, 0);
        break;
      end
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        check("reset_drq", drq, 0);
        check("reset_busy", busy, 0);
        tick;
        reset = 1'b0;
        break;
      end
      drq_ack = ack;
      tick;
      drq_ack = 1'b0;
      tick; tick;
    end
    idx_bad = bad;
    tick; tick;
    sector_data = 1'b0;
    tick; tick;
  endtask

  initial begin
    {start, cmd_write, cmd_multi, abort, dclk_en, sector_hdr, sector_data, drq_ack} = '0;
    {cmd_track, track, cmd_sector, sector} = '0;
    reset = 1'b1;
    index = 1'b1;
    ready = 1'b1;
    sector_len = 11'd512;
    sector_base = 1'b1;
    spt = 5'd10;
    tick; tick;
    reset = 1'b0;
    tick;
    check("rst_drq", drq, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_status", {rnf, lost_data, not_ready}, 0);
    check("rst_byte_idx", byte_idx, 0);
    check("rst_cur_sector", cur_sector, 0);

    launch(0, 0, 7'd5, 5'd3);
    check("rd_busy", busy, 1);
    check("rd_cur_sector", cur_sector, 3);
    hdr(7'd5, 5'd2);
    hdr(7'd6, 5'd3);
    check("rd_hdr_ignored", {drq, done, busy}, 3'b001);
    hdr(7'd5, 5'd3);
    data_phase(512, 1, -1, -1);
    wait_idle(20);
    check("rd_drq_pulses", drq_rises - r0, 512);
    check("rd_byte_idx_seq", idx_bad, 0);
    check("rd_done", done_cnt - d0, 1);
    check("rd_status", {rnf, lost_data, not_ready}, 0);

    launch(0, 0, 7'd5, 5'd3);
    hdr(7'd5, 5'd3);
    data_phase(512, 0, -1, -1);
    wait_idle(20);
    check("noack_lost_b0", lost0, 0);
    check("noack_lost_b1", lost1, 1);
    check("noack_byte_idx_seq", idx_bad, 0);
    check("noack_done", done_cnt - d0, 1);
    check("noack_lost", lost_data, 1);
    drq_ack = 1'b1;
    tick;
    drq_ack = 1'b0;
    check("ack_clears_drq", drq, 0);

    launch(0, 0, 7'd5, 5'd12);
    check("rnf_cleared", lost_data, 0);
    cmd_sector = 5'd4;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("start_while_busy", cur_sector, 12);
    hdr(7'd5, 5'd1);
    for (int k = 0; k < 4; k++) index_pulse;
    check("rnf_after_4", {rnf, busy}, 2'b01);
    index_pulse;
    wait_idle(20);
    check("rnf_after_5", rnf, 1);
    check("rnf_no_drq", drq_rises - r0, 0);
    check("rnf_done", done_cnt - d0, 1);

    launch(1, 0, 7'd5, 5'd2);
    hdr(7'd5, 5'd2);
    check("wr_drq_entry", drq, 1);
    check("wr_rnf_cleared", rnf, 0);
    sector_data = 1'b1;
    tick; tick; tick;
    check("wr_lost", lost_data, 1);
    for (int k = 0; k < 3; k++) begin
      dclk_en = 1'b1;
      tick;
      dclk_en = 1'b0;
      tick;
    end
    sector_data = 1'b0;
    wait_idle(20);
    check("wr_no_data_strobes", drq_rises - r0, 1);
    check("wr_done", done_cnt - d0, 1);
    check("wr_drq_low", drq, 0);

    sector_len = 11'd4;
    launch(0, 1, 7'd5, 5'd9);
    hdr(7'd5, 5'd9);
    data_phase(4, 1, -1, -1);
    check("multi_next_sector", cur_sector, 10);
    check("multi_mid", {busy, rnf, done_cnt - d0 == 0}, 3'b101);
    hdr(7'd5, 5'd10);
    data_phase(4, 1, -1, -1);
    wait_idle(20);
    check("multi_rnf", rnf, 1);
    check("multi_drq_pulses", drq_rises - r0, 8);
    check("multi_done", done_cnt - d0, 1);
    check("multi_lost", lost_data, 0);

    sector_len = 11'd512;
    launch(0, 0, 7'd5, 5'd3);
    hdr(7'd5, 5'd3);
    data_phase(512, 1, 100, -1);
    check("abort_done_once", done_cnt - d0, 1);

    launch(0, 0, 7'd5, 5'd3);
    hdr(7'd5, 5'd3);
    data_phase(512, 1, -1, 50);
    check("reset_idle", {busy, drq, byte_idx}, 0);

    ready = 1'b0;
    launch(0, 0, 7'd5, 5'd3);
    tick;
    check("nrdy_flag", not_ready, 1);
    wait_idle(20);
    check("nrdy_done", done_cnt - d0, 1);
    ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fdc_sector_seq.md
# fdc_sector_seq

Sector transfer sequencer that sits directly downstream of the virtual floppy drive in the fdc1772 tree. It consumes the drive's byte strobe, index, track/sector position and header/data windows. For a read or write sector command it locates the requested sector and paces the transfer as DRQ requests toward the CPU data register. It reports record-not-found, lost-data and not-ready status back to the command/status logic.

## Interface
Parameters:
- INDEX_TIMEOUT, 5: index pulses seen without a matching header before RNF.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; returns block to IDLE.
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- cmd_write  in  1  1 = write sector, 0 = read sector.
- cmd_multi  in  1  multi-sector: continue with sector+1 after each completed sector.
- cmd_track  in  7  expected track.
- cmd_sector  in  5  first sector number.
- sector_len  in  11  bytes per sector, 1..1024.
- sector_base  in  1  number of first sector on track (0 or 1).
- spt  in  5  sectors per track.
- abort  in  1  force interrupt; wins over every other event.
- dclk_en  in  1  drive byte strobe, one cycle wide.
- ready  in  1  drive ready.
- index  in  1  drive index; low for the pulse, start of revolution = falling edge.
- track  in  7  track under head.
- sector  in  5  sector under head.
- sector_hdr  in  1  header window.
- sector_data  in  1  data window.
- drq  out  1  byte request to CPU side.
- drq_ack  in  1  CPU serviced the data register.
- byte_idx  out  11  index of current byte within sector.
- cur_sector  out  5  sector currently targeted.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- rnf, lost_data, not_ready  out  1 each  status; sticky until next accepted start.

## Operation
States: IDLE, SEARCH, WAIT_DATA, XFER, FINISH.
- IDLE, start: clear status, latch command, cur_sector <= cmd_sector, idx_cnt <= 0.
  - If !ready, go to FINISH with not_ready=1.
  - Otherwise go to SEARCH.
- SEARCH:
  - Each index falling edge increments idx_cnt. At idx_cnt == INDEX_TIMEOUT, set rnf and go to FINISH.
  - On rising edge of sector_hdr with sector == cur_sector and track == cmd_track, go to WAIT_DATA.
  - A header match with a track mismatch is ignored.
- WAIT_DATA:
  - Write command: drq asserted on entry (first byte fetched one byte ahead).
  - On rising edge of sector_data: if write and drq still set, set lost_data and go to FINISH; otherwise byte_idx <= 0 and go to XFER.
- XFER, on each dclk_en while sector_data:
  - If drq is set and drq_ack is not asserted the same cycle, set lost_data; the transfer continues.
  - Set drq; increment byte_idx after the first byte.
  - After the sector_len-th strobe, sector complete.
  - If sector_data falls before sector_len bytes, set lost_data and go to FINISH.
- Sector complete:
  - If cmd_multi, advance cur_sector. Past sector_base+spt-1, set rnf and go to FINISH; otherwise idx_cnt <= 0 and go to SEARCH.
  - If not cmd_multi, go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- abort in any non-IDLE state: go to FINISH next cycle, drq cleared, status unchanged.
- drq_ack clears drq on the next edge unless a new dclk_en arrives in that same cycle; then drq stays 1 and there is no lost_data.

## Timing
- Reset values: drq=0, busy=0, done=0, rnf=0, lost_data=0, not_ready=0, byte_idx=0, cur_sector=0; state IDLE.
- busy rises the cycle after start and falls the cycle after done.
- Edges (index, sector_hdr, sector_data) are detected with a one-flop history, so the reaction comes one cycle after the input edge.
- drq rises one cycle after the qualifying dclk_en.
- start while busy is ignored. reset mid-transfer drops drq asynchronously.
- byte_idx is 11 bits wide and never exceeds sector_len-1. idx_cnt is 3 bits and saturates.

## Structure
- Shared header fdc_pkg: state encodings, status bit positions (RNF, LOST, NRDY), INDEX_TIMEOUT default.
- One natural sub-module, fdc_edge_det: registered rise/fall detector, instantiated for index, sector_hdr and sector_data.

## Test plan
- Read, sector_len=512, cmd_sector=3, track match: exactly 512 drq pulses with byte_idx 0..511, done once, all status 0.
- Read with CPU never acking: lost_data=1 from byte 2 onward; the transfer still completes with 512 strobes.
- cmd_sector=12, spt=10, sector_base=1: rnf=1 after the 5th index falling edge; no drq ever.
- Write, no ack before sector_data rises: lost_data=1, done immediately, zero data-phase strobes.
- Multi read from sector 9, spt=10, base=1: sectors 9 and 10 are transferred, then rnf=1 and done.
- abort asserted mid-XFER at byte 100: drq=0 next cycle, done pulse, busy low afterwards, status unchanged. Also: reset asserted mid-transfer drops drq immediately.
